// File: rtl/bm_sched.sv
// bm_sched: issue scheduler for the Box-Muller AWGN pipeline.
// Issues (u0,u1) pairs to the log/sqrt and sinusoidal blocks, delay-matches
// g0/g1 to f, and queues {f,g0,g1} in a credit-protected output FIFO.
// Optional build macro BM_SCHED_STATS_EN adds stall/starve cycle counters.
module bm_sched #(
  parameter int SINO_LAT   = 2,
  parameter int F_LAT      = 6,
  parameter int U0_W       = 48,
  parameter int F_W        = 17,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    stop,
  input  logic [CNT_W-1:0]        num_samples,
  input  logic                    urng_valid,
  input  logic [U0_W-1:0]         urng_u0,
  input  logic [15:0]             urng_u1,
  output logic                    urng_ready,
  output logic [15:0]             sino_u1,
  output logic [U0_W-1:0]         fs_u0,
  input  logic signed [15:0]      sino_g0,
  input  logic signed [15:0]      sino_g1,
  input  logic [F_W-1:0]          fs_f,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [F_W-1:0]          out_f,
  output logic signed [15:0]      out_g0,
  output logic signed [15:0]      out_g1,
  output logic                    busy,
`ifdef BM_SCHED_STATS_EN
  output logic [CNT_W-1:0]        stall_cnt,
  output logic [CNT_W-1:0]        starve_cnt,
`endif
  output logic                    done
);

  localparam int G_DLY = F_LAT - SINO_LAT;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int INF_W = $clog2(F_LAT + 1);
  localparam int OCC_W = $clog2(F_LAT + FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    r_done;
  logic [CNT_W-1:0]        r_issued;
  logic [F_LAT-1:0]        r_tag;       // bit i = sample at pipeline stage i+1
  logic [15:0]             r_sino_u1;
  logic [U0_W-1:0]         r_fs_u0;
  logic [INF_W-1:0]        w_inflight;
  logic                    w_issue;
  logic                    w_last;
  logic                    w_credit_ok;
  logic                    w_push;
  logic                    w_pop;
  logic signed [15:0]      w_g0_d;
  logic signed [15:0]      w_g1_d;

  logic [F_W-1:0]          r_f_mem  [FIFO_DEPTH];
  logic signed [15:0]      r_g0_mem [FIFO_DEPTH];
  logic signed [15:0]      r_g1_mem [FIFO_DEPTH];
  logic [PTR_W:0]          r_wptr;
  logic [PTR_W:0]          r_rptr;
  logic [PTR_W:0]          w_count;

  // In-flight sample count: population count of the tag pipeline.
  always_comb begin
    w_inflight = {INF_W{1'b0}};
    for (int i = 0; i < F_LAT; i++) begin
      w_inflight = w_inflight + INF_W'(r_tag[i]);
    end
  end

  assign w_count     = r_wptr - r_rptr;
  // Everything in flight must still fit in the FIFO if the consumer stalls.
  assign w_credit_ok = (OCC_W'(w_inflight) + OCC_W'(w_count)) < OCC_W'(FIFO_DEPTH);
  assign w_last      = (num_samples != {CNT_W{1'b0}}) && (r_issued == num_samples);
  assign urng_ready  = (r_state == ST_RUN) && w_credit_ok && !w_last;
  assign w_issue     = urng_valid && urng_ready;
  assign w_push      = r_tag[F_LAT-1];
  assign w_pop       = out_valid && out_ready;

  // Burst sequencing: next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start && !stop) w_state_nxt = ST_RUN;
        else                w_state_nxt = ST_IDLE;
      end
      ST_RUN: begin
        if (stop || w_last) w_state_nxt = ST_DRAIN;
        else                w_state_nxt = ST_RUN;
      end
      ST_DRAIN: begin
        if ((w_inflight == {INF_W{1'b0}}) && (w_count == {(PTR_W+1){1'b0}})) w_state_nxt = ST_IDLE;
        else                                                                  w_state_nxt = ST_DRAIN;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register, done pulse and issued-sample counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_done   <= 1'b0;
      r_issued <= {CNT_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_done  <= (r_state == ST_DRAIN) && (w_state_nxt == ST_IDLE);
      if ((r_state == ST_IDLE) && (w_state_nxt == ST_RUN)) r_issued <= {CNT_W{1'b0}};
      else if (w_issue)                                     r_issued <= r_issued + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Issue registers towards the two math blocks plus the valid-tag pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sino_u1 <= 16'd0;
      r_fs_u0   <= {U0_W{1'b0}};
      r_tag     <= {F_LAT{1'b0}};
    end else begin
      if (w_issue) begin
        r_sino_u1 <= urng_u1;
        r_fs_u0   <= urng_u0;
      end
      r_tag <= {r_tag[F_LAT-2:0], w_issue};
    end
  end

  // g0/g1 captured when the tag reaches the sinusoid stage, then aligned to f.
  generate
    if (G_DLY > 0) begin : g_dly_gen
      logic signed [15:0] r_g0_dly [G_DLY];
      logic signed [15:0] r_g1_dly [G_DLY];
      // Delay line; stage 0 loads only when a sample's sinusoid result is valid.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < G_DLY; i++) begin
            r_g0_dly[i] <= 16'sd0;
            r_g1_dly[i] <= 16'sd0;
          end
        end else begin
          if (r_tag[SINO_LAT-1]) begin
            r_g0_dly[0] <= sino_g0;
            r_g1_dly[0] <= sino_g1;
          end
          for (int i = 1; i < G_DLY; i++) begin
            r_g0_dly[i] <= r_g0_dly[i-1];
            r_g1_dly[i] <= r_g1_dly[i-1];
          end
        end
      end
      assign w_g0_d = r_g0_dly[G_DLY-1];
      assign w_g1_d = r_g1_dly[G_DLY-1];
    end else begin : g_nodly_gen
      assign w_g0_d = sino_g0;
      assign w_g1_d = sino_g1;
    end
  endgenerate

  // Output FIFO storage and pointers; credit issue guarantees no push when full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= {(PTR_W+1){1'b0}};
      r_rptr <= {(PTR_W+1){1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_f_mem[i]  <= {F_W{1'b0}};
        r_g0_mem[i] <= 16'sd0;
        r_g1_mem[i] <= 16'sd0;
      end
    end else begin
      if (w_push) begin
        r_f_mem[r_wptr[PTR_W-1:0]]  <= fs_f;
        r_g0_mem[r_wptr[PTR_W-1:0]] <= w_g0_d;
        r_g1_mem[r_wptr[PTR_W-1:0]] <= w_g1_d;
        r_wptr <= r_wptr + {{PTR_W{1'b0}}, 1'b1};
      end
      if (w_pop) begin
        r_rptr <= r_rptr + {{PTR_W{1'b0}}, 1'b1};
      end
    end
  end

`ifdef BM_SCHED_STATS_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_starve_cnt;

  // Saturating stall/starve counters, cleared at the start of each burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt  <= {CNT_W{1'b0}};
      r_starve_cnt <= {CNT_W{1'b0}};
    end else if ((r_state == ST_IDLE) && (w_state_nxt == ST_RUN)) begin
      r_stall_cnt  <= {CNT_W{1'b0}};
      r_starve_cnt <= {CNT_W{1'b0}};
    end else if (r_state == ST_RUN) begin
      if (urng_valid && !urng_ready && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      if (!urng_valid && (r_starve_cnt != {CNT_W{1'b1}}))
        r_starve_cnt <= r_starve_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign starve_cnt = r_starve_cnt;
`endif

  assign sino_u1   = r_sino_u1;
  assign fs_u0     = r_fs_u0;
  assign out_valid = (w_count != {(PTR_W+1){1'b0}});
  assign out_f     = r_f_mem[r_rptr[PTR_W-1:0]];
  assign out_g0    = r_g0_mem[r_rptr[PTR_W-1:0]];
  assign out_g1    = r_g1_mem[r_rptr[PTR_W-1:0]];
  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;

endmodule
